// File: rtl/palette_pkg.sv
// Shared types, FSM state encoding and the default palette for the colour look-up table.
// The invert option is enabled with the macro PALETTE_INVERT_EN.
package palette_pkg;

    typedef enum logic {ST_INIT, ST_RUN} init_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    // Wide enough for any channel width up to 32 bits; callers cast down to CH_W.
    typedef struct packed {
        logic [31:0] r;
        logic [31:0] g;
        logic [31:0] b;
    } rgb_wide_t;

    localparam int PAL_ENTRIES = 16;

    localparam rgb8_t DEFAULT_PAL [PAL_ENTRIES] = '{
        '{8'h80, 8'h00, 8'h80}, '{8'hEF, 8'hEF, 8'hEF}, '{8'hF0, 8'hF0, 8'hF0}, '{8'hF6, 8'hF6, 8'hF6},
        '{8'hF7, 8'hF7, 8'hF7}, '{8'hF8, 8'hF8, 8'hF8}, '{8'hFE, 8'hFE, 8'hFE}, '{8'hFF, 8'hFF, 8'hFF},
        '{8'h53, 8'h53, 8'h53}, '{8'hB9, 8'hB9, 8'hB9}, '{8'hDA, 8'hDA, 8'hDA}, '{8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00}
    };

    // Places an 8-bit value at the top of a ch_w-bit channel (zero-fill or truncate the LSBs).
    function automatic logic [31:0] msb_align(input logic [7:0] v, input int ch_w);
        logic [31:0] w;
        w = {24'd0, v};
        return (ch_w >= 8) ? (w << (ch_w - 8)) : (w >> (8 - ch_w));
    endfunction

    function automatic rgb_wide_t default_entry(input int idx, input int ch_w);
        rgb_wide_t e;
        e = '0;
        if (idx >= 0 && idx < PAL_ENTRIES) begin
            e.r = msb_align(DEFAULT_PAL[idx].r, ch_w);
            e.g = msb_align(DEFAULT_PAL[idx].g, ch_w);
            e.b = msb_align(DEFAULT_PAL[idx].b, ch_w);
        end
        return e;
    endfunction

endpackage

// File: rtl/palette_clut_if.sv
// Lookup, table-write and result signals of the colour look-up table.
// The invert input exists only when PALETTE_INVERT_EN is defined.
interface palette_clut_if #(
    parameter int IDX_W = 4,
    parameter int CH_W  = 8
);
    logic              pix_valid_in;
    logic [IDX_W-1:0]  color_in;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [3*CH_W-1:0] wr_rgb;
    logic              wr_transp;
    logic              reload;
`ifdef PALETTE_INVERT_EN
    logic              invert;
`endif
    logic              init_busy;
    logic              pix_valid_out;
    logic              istransparent;
    logic [CH_W-1:0]   Red;
    logic [CH_W-1:0]   Green;
    logic [CH_W-1:0]   Blue;

    modport master (
`ifdef PALETTE_INVERT_EN
        output invert,
`endif
        output pix_valid_in, color_in, wr_en, wr_idx, wr_rgb, wr_transp, reload,
        input  init_busy, pix_valid_out, istransparent, Red, Green, Blue
    );

    modport slave (
`ifdef PALETTE_INVERT_EN
        input  invert,
`endif
        input  pix_valid_in, color_in, wr_en, wr_idx, wr_rgb, wr_transp, reload,
        output init_busy, pix_valid_out, istransparent, Red, Green, Blue
    );
endinterface

// File: rtl/palette_init_fsm.sv
// INIT/RUN sequencer: loads the default palette after reset or reload, then passes
// user writes through to the single table write port.
module palette_init_fsm
    import palette_pkg::*;
#(
    parameter int IDX_W      = 4,
    parameter int CH_W       = 8,
    parameter int TRANSP_IDX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reload,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [3*CH_W-1:0] wr_rgb,
    input  logic              wr_transp,
    output logic              init_busy,
    output logic              tbl_we,
    output logic [IDX_W-1:0]  tbl_idx,
    output logic [3*CH_W-1:0] tbl_rgb,
    output logic              tbl_transp
);
    localparam int DEPTH = 2**IDX_W;

    init_state_t state, state_nxt;
    logic [IDX_W:0] cnt, cnt_nxt;
    rgb_wide_t def;

    // NOTE: state registers use non-blocking assignments; the decode below is purely combinational.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        tbl_we     = 1'b0;
        tbl_idx    = wr_idx;
        tbl_rgb    = wr_rgb;
        tbl_transp = wr_transp;
        def        = default_entry(int'(cnt), CH_W);
        case (state)
            ST_INIT: begin
                tbl_we     = 1'b1;
                tbl_idx    = cnt[IDX_W-1:0];
                tbl_rgb    = {CH_W'(def.r), CH_W'(def.g), CH_W'(def.b)};
                tbl_transp = (int'(cnt) == TRANSP_IDX);
                if (cnt == (IDX_W+1)'(DEPTH - 1)) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                // A reload in the same cycle as a write wins; the write is dropped.
                if (reload) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end else begin
                    tbl_we = wr_en;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign init_busy = (state == ST_INIT);

endmodule

// File: rtl/palette_clut.sv
// Programmable two-stage colour look-up table: index -> {R,G,B} + transparency.
// Define PALETTE_INVERT_EN to add the night-mode invert input.
module palette_clut
    import palette_pkg::*;
#(
    parameter int IDX_W      = 4,
    parameter int CH_W       = 8,
    parameter int TRANSP_IDX = 0
) (
    input  logic           Clk,
    input  logic           Reset,
    palette_clut_if.slave  bus
);
    localparam int DEPTH = 2**IDX_W;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        rgb_t rgb;
        logic transp;
    } entry_t;

    entry_t            pal_mem [DEPTH];
    entry_t            rd;
    rgb_t              out_rgb;
    logic              init_busy;
    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_idx;
    logic [3*CH_W-1:0] tbl_rgb;
    logic              tbl_transp;
    logic              s1_valid;
    logic [IDX_W-1:0]  s1_idx;
    logic              s1_inv;

    palette_init_fsm #(
        .IDX_W      (IDX_W),
        .CH_W       (CH_W),
        .TRANSP_IDX (TRANSP_IDX)
    ) u_init_fsm (
        .clk        (Clk),
        .rst        (Reset),
        .reload     (bus.reload),
        .wr_en      (bus.wr_en),
        .wr_idx     (bus.wr_idx),
        .wr_rgb     (bus.wr_rgb),
        .wr_transp  (bus.wr_transp),
        .init_busy  (init_busy),
        .tbl_we     (tbl_we),
        .tbl_idx    (tbl_idx),
        .tbl_rgb    (tbl_rgb),
        .tbl_transp (tbl_transp)
    );

    assign bus.init_busy = init_busy;

    // NOTE: the table has no reset; the INIT sequence rewrites every entry after reset.
    always_ff @(posedge Clk) begin
        if (tbl_we) pal_mem[tbl_idx] <= {tbl_rgb, tbl_transp};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= bus.pix_valid_in && !init_busy;
            s1_idx   <= bus.color_in;
        end
    end

`ifdef PALETTE_INVERT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) s1_inv <= 1'b0;
        else       s1_inv <= bus.invert;
    end
`else
    assign s1_inv = 1'b0;
`endif

    // The table is read one edge after the index is sampled, so a same-edge write is visible.
    always_comb begin
        rd      = pal_mem[s1_idx];
        out_rgb = (s1_inv && !rd.transp) ? rgb_t'(~rd.rgb) : rd.rgb;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.pix_valid_out <= 1'b0;
            bus.istransparent <= 1'b0;
            bus.Red           <= '0;
            bus.Green         <= '0;
            bus.Blue          <= '0;
        end else begin
            bus.pix_valid_out <= s1_valid;
            if (s1_valid) begin
                bus.istransparent <= rd.transp;
                bus.Red           <= out_rgb.r;
                bus.Green         <= out_rgb.g;
                bus.Blue          <= out_rgb.b;
            end
        end
    end

endmodule

// File: tb/tb_palette_clut.sv
// Self-checking bench for palette_clut: vector table plus scoreboard of expected lookups.
// Covers the PALETTE_INVERT_EN build when that macro is defined.
module tb_palette_clut;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    palette_clut_if #(.IDX_W(4), .CH_W(8)) bus ();

    palette_clut #(.IDX_W(4), .CH_W(8), .TRANSP_IDX(0)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [23:0] rgb;
        logic        t;
    } exp_t;

    typedef struct {
        logic [3:0]  idx;
        logic [23:0] rgb;
        logic        t;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // Scoreboard: each valid result must match the oldest outstanding lookup, two edges later.
    always @(negedge Clk) begin
        if (bus.pix_valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rgb", {8'd0, bus.Red, bus.Green, bus.Blue}, {8'd0, mon_e.rgb});
                check("transp", {31'd0, bus.istransparent}, {31'd0, mon_e.t});
                check("latency", cyc, mon_e.cyc + 2);
            end
        end
    end

    task automatic lookup(input logic [3:0] idx, input logic [23:0] rgb, input logic t);
        bus.pix_valid_in = 1'b1;
        bus.color_in     = idx;
`ifdef PALETTE_INVERT_EN
        bus.invert       = 1'b0;
`endif
        sb.push_back('{cyc, rgb, t});
        @(posedge Clk); #1;
        bus.pix_valid_in = 1'b0;
    endtask

`ifdef PALETTE_INVERT_EN
    task automatic lookup_inv(input logic [3:0] idx, input logic [23:0] rgb, input logic t);
        bus.pix_valid_in = 1'b1;
        bus.color_in     = idx;
        bus.invert       = 1'b1;
        sb.push_back('{cyc, rgb, t});
        @(posedge Clk); #1;
        bus.pix_valid_in = 1'b0;
        bus.invert       = 1'b0;
    endtask
`endif

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge Clk); #1;
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (bus.init_busy === 1'b1 && n < 40) begin
            @(posedge Clk); #1;
            n++;
        end
    endtask

    vec_t vecs [10];
    int   n_init;

    initial begin
        vecs = '{
            '{4'h8, 24'h535353, 1'b0}, '{4'h0, 24'h800080, 1'b1}, '{4'hF, 24'h000000, 1'b0},
            '{4'h1, 24'hEFEFEF, 1'b0}, '{4'h2, 24'hF0F0F0, 1'b0}, '{4'h8, 24'h535353, 1'b0},
            '{4'hA, 24'hDADADA, 1'b0}, '{4'hB, 24'h000000, 1'b0}, '{4'h7, 24'hFFFFFF, 1'b0},
            '{4'h9, 24'hB9B9B9, 1'b0}
        };
        bus.pix_valid_in = 1'b0;
        bus.color_in     = '0;
        bus.wr_en        = 1'b0;
        bus.wr_idx       = '0;
        bus.wr_rgb       = '0;
        bus.wr_transp    = 1'b0;
        bus.reload       = 1'b0;
`ifdef PALETTE_INVERT_EN
        bus.invert       = 1'b0;
`endif

        // Reset values
        #12;
        check("rst_init_busy", {31'd0, bus.init_busy}, 32'd1);
        check("rst_valid", {31'd0, bus.pix_valid_out}, 32'd0);
        check("rst_rgb", {8'd0, bus.Red, bus.Green, bus.Blue}, 32'd0);
        check("rst_transp", {31'd0, bus.istransparent}, 32'd0);

        // Lookups requested during INIT must never produce a result.
        @(negedge Clk);
        Reset = 1'b0;
        bus.pix_valid_in = 1'b1;
        bus.color_in     = 4'h8;
        wait_init(n_init);
        bus.pix_valid_in = 1'b0;
        check("init_cycles", n_init, 16);

        // Back-to-back table vectors, one per cycle
        for (int i = 0; i < 10; i++) lookup(vecs[i].idx, vecs[i].rgb, vecs[i].t);
        drain();

        // Outputs hold the last valid result while idle
        repeat (3) begin
            @(negedge Clk);
            check("hold_valid", {31'd0, bus.pix_valid_out}, 32'd0);
            check("hold_rgb", {8'd0, bus.Red, bus.Green, bus.Blue}, 32'h00B9B9B9);
        end
        @(posedge Clk); #1;

        // Lookup one edge before the write sees old data; same-edge lookup sees new data.
        lookup(4'h3, 24'hF6F6F6, 1'b0);
        bus.wr_en     = 1'b1;
        bus.wr_idx    = 4'h3;
        bus.wr_rgb    = 24'h123456;
        bus.wr_transp = 1'b0;
        lookup(4'h3, 24'h123456, 1'b0);
        bus.wr_idx    = 4'h5;
        bus.wr_rgb    = 24'hAABBCC;
        bus.wr_transp = 1'b1;
        lookup(4'h5, 24'hAABBCC, 1'b1);
        bus.wr_en     = 1'b0;
        lookup(4'h3, 24'h123456, 1'b0);
        drain();

        // Reload wins over a simultaneous write
        bus.reload = 1'b1;
        bus.wr_en  = 1'b1;
        bus.wr_idx = 4'h3;
        bus.wr_rgb = 24'h000000;
        @(posedge Clk); #1;
        bus.reload = 1'b0;
        bus.wr_en  = 1'b0;
        check("reload_busy", {31'd0, bus.init_busy}, 32'd1);
        bus.pix_valid_in = 1'b1;
        bus.color_in     = 4'h3;
        wait_init(n_init);
        bus.pix_valid_in = 1'b0;
        check("reload_cycles", n_init, 16);
        lookup(4'h3, 24'hF6F6F6, 1'b0);
        lookup(4'h5, 24'hF8F8F8, 1'b0);
        drain();

        // Reset with a lookup in flight: discarded, outputs cleared immediately.
        bus.pix_valid_in = 1'b1;
        bus.color_in     = 4'h1;
        @(posedge Clk); #1;
        bus.pix_valid_in = 1'b0;
        #2 Reset = 1'b1;
        #1;
        check("rst_fly_valid", {31'd0, bus.pix_valid_out}, 32'd0);
        check("rst_fly_rgb", {8'd0, bus.Red, bus.Green, bus.Blue}, 32'd0);
        check("rst_fly_busy", {31'd0, bus.init_busy}, 32'd1);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Reset part-way through INIT restarts the full load.
        repeat (7) begin @(posedge Clk); #1; end
        check("mid_init_busy", {31'd0, bus.init_busy}, 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("mid_init_rgb", {8'd0, bus.Red, bus.Green, bus.Blue}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        wait_init(n_init);
        check("restart_cycles", n_init, 16);
        lookup(4'h1, 24'hEFEFEF, 1'b0);
        lookup(4'h0, 24'h800080, 1'b1);
        drain();

`ifdef PALETTE_INVERT_EN
        lookup_inv(4'h8, 24'hACACAC, 1'b0);
        lookup_inv(4'h0, 24'h800080, 1'b1);
        lookup(4'h8, 24'h535353, 1'b0);
        lookup_inv(4'h3, 24'h090909, 1'b0);
        drain();
`endif

        repeat (3) @(posedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
